// File: rtl/ctrl_pkg.sv
// Shared constants for the Phase-1 control sequencer: opcodes, IR field
// positions, state encoding and small opcode classification helpers.
package ctrl_pkg;

  // Opcodes
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU code used while incrementing the PC during fetch
  localparam logic [4:0] INC_PC_ALU = OP_ADD;

  // IR field bit positions
  localparam int unsigned OP_MSB = 31;
  localparam int unsigned OP_LSB = 27;
  localparam int unsigned RA_MSB = 26;
  localparam int unsigned RA_LSB = 23;
  localparam int unsigned RB_MSB = 22;
  localparam int unsigned RB_LSB = 19;
  localparam int unsigned RC_MSB = 18;
  localparam int unsigned RC_LSB = 15;

  // State encoding
  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_F0    = 4'd1;
  localparam logic [3:0] S_F1    = 4'd2;
  localparam logic [3:0] S_F2    = 4'd3;
  localparam logic [3:0] S_T3    = 4'd4;
  localparam logic [3:0] S_T4    = 4'd5;
  localparam logic [3:0] S_T5    = 4'd6;
  localparam logic [3:0] S_T6    = 4'd7;
  localparam logic [3:0] S_HALT  = 4'd8;
  localparam logic [3:0] S_FAULT = 4'd9;

  // Two-operand ops: Y <- R[Rb], then ALU with R[Rc]
  function automatic logic is_binary(input logic [4:0] op);
    return ((op >= OP_ADD) && (op <= OP_SHL)) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

  // One-operand ops: ALU applied to R[Rb]
  function automatic logic is_unary(input logic [4:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  // Ops whose result lands in Hi:Lo instead of a general register
  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/ctrl_reg_decoder.sv
// 4-bit register index to 16-bit one-hot select, gated by an enable.
module ctrl_reg_decoder (
  input  logic [3:0]  idx,
  input  logic        en,
  output logic [15:0] onehot
);

  // One-hot expansion; all zeros when disabled
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit sequencing fetch and execute for the
// Phase-1 datapath. Strobes decode from the state register and the IR.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             stop,
  input  logic [31:0]      ir,
  input  logic             mem_ready,
  output logic [15:0]      regIn,
  output logic [15:0]      regOut,
  output logic             HiIn,
  output logic             LoIn,
  output logic             ZIn,
  output logic             PCIn,
  output logic             MDRIn,
  output logic             YIn,
  output logic             IRIn,
  output logic             MARIn,
  output logic             IncPC,
  output logic             HiOut,
  output logic             LoOut,
  output logic             ZHiOut,
  output logic             ZLoOut,
  output logic             PCOut,
  output logic             MDROut,
  output logic             MDRread,
  output logic [4:0]       ALUcode,
  output logic             done,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  logic [3:0]        state;
  logic [3:0]        state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [4:0]        op;
  logic [3:0]        ra;
  logic [3:0]        rb;
  logic [3:0]        rc;
  logic              alu_op;
  logic              muldiv;
  logic              count_inc;
  logic              unused_ir_low;

  assign op            = ir[OP_MSB:OP_LSB];
  assign ra            = ir[RA_MSB:RA_LSB];
  assign rb            = ir[RB_MSB:RB_LSB];
  assign rc            = ir[RC_MSB:RC_LSB];
  assign alu_op        = is_binary(op) || is_unary(op);
  assign muldiv        = is_muldiv(op);
  assign unused_ir_low = ^ir[14:0];

  // Instruction completion: every done pulse plus the entry into HALT
  assign count_inc = done || ((state == S_T3) && (op == OP_HALT));

  // Next-state logic; the instruction boundary folds into the last state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_F0;
      S_F0:    state_nxt = S_F1;
      S_F1: begin
        if (mem_ready)                                  state_nxt = S_F2;
        else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1))  state_nxt = S_FAULT;
      end
      S_F2:    state_nxt = S_T3;
      S_T3: begin
        if (op == OP_NOP)       state_nxt = stop ? S_IDLE : S_F0;
        else if (op == OP_HALT) state_nxt = S_HALT;
        else if (alu_op)        state_nxt = S_T4;
        else                    state_nxt = S_FAULT;
      end
      S_T4:    state_nxt = S_T5;
      S_T5:    state_nxt = muldiv ? S_T6 : (stop ? S_IDLE : S_F0);
      S_T6:    state_nxt = stop ? S_IDLE : S_F0;
      S_HALT:  if (start) state_nxt = S_F0;
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, memory-wait counter and completed-instruction counter
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      if ((state == S_F1) && !mem_ready) wait_cnt <= wait_cnt + WAIT_W'(1);
      else                               wait_cnt <= '0;
      if (count_inc) instr_count <= instr_count + CNT_W'(1);
    end
  end

  // Per-state strobes; at most one bus driver is asserted in any state
  always_comb begin
    HiIn    = 1'b0;
    LoIn    = 1'b0;
    ZIn     = 1'b0;
    PCIn    = 1'b0;
    MDRIn   = 1'b0;
    YIn     = 1'b0;
    IRIn    = 1'b0;
    MARIn   = 1'b0;
    IncPC   = 1'b0;
    HiOut   = 1'b0;
    LoOut   = 1'b0;
    ZHiOut  = 1'b0;
    ZLoOut  = 1'b0;
    PCOut   = 1'b0;
    MDROut  = 1'b0;
    MDRread = 1'b0;
    ALUcode = '0;
    done    = 1'b0;
    halted  = 1'b0;
    fault   = 1'b0;
    case (state)
      S_F0: begin
        PCOut   = 1'b1;
        MARIn   = 1'b1;
        IncPC   = 1'b1;
        ZIn     = 1'b1;
        ALUcode = INC_PC_ALU;
      end
      S_F1: begin
        ZLoOut  = 1'b1;
        PCIn    = 1'b1;
        MDRread = 1'b1;
        MDRIn   = 1'b1;
      end
      S_F2: begin
        MDROut = 1'b1;
        IRIn   = 1'b1;
      end
      S_T3: begin
        YIn  = alu_op;
        done = (op == OP_NOP);
      end
      S_T4: begin
        ZIn     = 1'b1;
        ALUcode = op;
      end
      S_T5: begin
        ZLoOut = 1'b1;
        LoIn   = muldiv;
        done   = !muldiv;
      end
      S_T6: begin
        ZHiOut = 1'b1;
        HiIn   = 1'b1;
        done   = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: ;
    endcase
  end

  // Destination write in T5 for non-Hi:Lo results
  ctrl_reg_decoder u_reg_in (
    .idx    (ra),
    .en     ((state == S_T5) && !muldiv),
    .onehot (regIn)
  );

  // Source drive: Rb in T3 and for unary T4, Rc for binary T4
  ctrl_reg_decoder u_reg_out (
    .idx    (((state == S_T4) && is_binary(op)) ? rc : rb),
    .en     (((state == S_T3) || (state == S_T4)) && alu_op),
    .onehot (regOut)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with a small behavioural datapath
// model that executes the strobes, so results land in model registers.
module tb_control_sequencer;

  logic        clock;
  logic        clear;
  logic        start;
  logic        stop;
  logic [31:0] ir;
  logic        mem_ready;
  logic [15:0] regIn;
  logic [15:0] regOut;
  logic        HiIn, LoIn, ZIn, PCIn, MDRIn, YIn, IRIn, MARIn, IncPC;
  logic        HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut;
  logic        MDRread;
  logic [4:0]  ALUcode;
  logic        done;
  logic        halted;
  logic        fault;
  logic [15:0] instr_count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  control_sequencer #(.MEM_TIMEOUT(255), .CNT_W(16)) dut (
    .clock(clock), .clear(clear), .start(start), .stop(stop), .ir(ir),
    .mem_ready(mem_ready), .regIn(regIn), .regOut(regOut),
    .HiIn(HiIn), .LoIn(LoIn), .ZIn(ZIn), .PCIn(PCIn), .MDRIn(MDRIn),
    .YIn(YIn), .IRIn(IRIn), .MARIn(MARIn), .IncPC(IncPC),
    .HiOut(HiOut), .LoOut(LoOut), .ZHiOut(ZHiOut), .ZLoOut(ZLoOut),
    .PCOut(PCOut), .MDROut(MDROut), .MDRread(MDRread), .ALUcode(ALUcode),
    .done(done), .halted(halted), .fault(fault), .instr_count(instr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Grouped strobes: loads = {HiIn,LoIn,ZIn,PCIn,MDRIn,YIn,IRIn,MARIn,IncPC}
  //                  drives = {HiOut,LoOut,ZHiOut,ZLoOut,PCOut,MDROut}
  logic [8:0] loads;
  logic [5:0] drives;
  assign loads  = {HiIn, LoIn, ZIn, PCIn, MDRIn, YIn, IRIn, MARIn, IncPC};
  assign drives = {HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut};

  // ---------------- behavioural datapath model ----------------
  logic [31:0] rf [16];
  logic [31:0] mem [16];
  logic [31:0] Y, PC, MAR, MDR, IR, Hi, Lo, bus;
  logic [63:0] Z;
  logic        init;

  assign ir = IR;

  always_comb begin
    bus = '0;
    for (int i = 0; i < 16; i++) if (regOut[i]) bus = bus | rf[i];
    if (HiOut)  bus = bus | Hi;
    if (LoOut)  bus = bus | Lo;
    if (ZHiOut) bus = bus | Z[63:32];
    if (ZLoOut) bus = bus | Z[31:0];
    if (PCOut)  bus = bus | PC;
    if (MDROut) bus = bus | MDR;
  end

  function automatic logic [63:0] alu(input logic [4:0] c, input logic [31:0] a,
                                      input logic [31:0] b);
    case (c)
      5'b00011: return {32'd0, a + b};
      5'b00100: return {32'd0, a - b};
      5'b00101: return {32'd0, a & b};
      5'b00110: return {32'd0, a | b};
      5'b01111: return {32'd0, a} * {32'd0, b};
      5'b10001: return {32'd0, -b};
      5'b10010: return {32'd0, ~b};
      default:  return 64'd0;
    endcase
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] o, input logic [3:0] a,
                                     input logic [3:0] b, input logic [3:0] c);
    return {o, a, b, c, 15'd0};
  endfunction

  always @(posedge clock) begin
    if (init) begin
      for (int i = 0; i < 16; i++) begin
        rf[i]  <= '0;
        mem[i] <= mk(5'b11010, 4'd0, 4'd0, 4'd0);
      end
      rf[3]  <= 32'h0000_000A;
      rf[7]  <= 32'h0000_000F;
      rf[2]  <= 32'h0001_2345;
      rf[5]  <= 32'h0001_0001;
      mem[0] <= 32'h2A1B_8000;                      // AND R4,R3,R7
      mem[1] <= mk(5'b01111, 4'd0, 4'd2, 4'd5);     // MUL R0,R2,R5
      mem[2] <= mk(5'b11010, 4'd0, 4'd0, 4'd0);     // NOP
      mem[3] <= mk(5'b11111, 4'd1, 4'd1, 4'd1);     // illegal
      mem[4] <= mk(5'b11011, 4'd0, 4'd0, 4'd0);     // HALT
      mem[5] <= mk(5'b00011, 4'd6, 4'd3, 4'd7);     // ADD R6,R3,R7
      mem[7] <= mk(5'b00011, 4'd1, 4'd3, 4'd7);     // ADD R1,R3,R7
      PC <= '0; MAR <= '0; MDR <= '0; IR <= '0; Y <= '0; Z <= '0; Hi <= '0; Lo <= '0;
    end else begin
      if (MARIn) MAR <= bus;
      if (IncPC) Z <= {32'd0, bus + 32'd1};
      else if (ZIn) Z <= alu(ALUcode, Y, bus);
      if (PCIn)  PC  <= bus;
      if (MDRIn) MDR <= MDRread ? mem[MAR[3:0]] : bus;
      if (IRIn)  IR  <= bus;
      if (YIn)   Y   <= bus;
      if (HiIn)  Hi  <= bus;
      if (LoIn)  Lo  <= bus;
      for (int i = 0; i < 16; i++) if (regIn[i]) rf[i] <= bus;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [8:0] l, input logic [5:0] d,
                        input logic [15:0] ri, input logic [15:0] ro,
                        input logic [4:0] a, input logic dn);
    chk({tag, ".loads"},  {55'd0, loads},  {55'd0, l});
    chk({tag, ".drives"}, {58'd0, drives}, {58'd0, d});
    chk({tag, ".regIn"},  {48'd0, regIn},  {48'd0, ri});
    chk({tag, ".regOut"}, {48'd0, regOut}, {48'd0, ro});
    chk({tag, ".alu"},    {59'd0, ALUcode}, {59'd0, a});
    chk({tag, ".done"},   {63'd0, done},   {63'd0, dn});
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    clear = 1'b1; start = 1'b0; stop = 1'b0; mem_ready = 1'b1; init = 1'b1;
    tick();
    init = 1'b0;
    chk_st("reset", 9'd0, 6'd0, 16'd0, 16'd0, 5'd0, 1'b0);
    chk("reset.count", {48'd0, instr_count}, 64'd0);
    chk("reset.flags", {61'd0, MDRread, halted, fault}, 64'd0);
    clear = 1'b0;
    tick();
    chk("idle.drives", {58'd0, drives}, 64'd0);

    // AND R4,R3,R7
    pulse_start();
    chk_st("and.f0", 9'b001000011, 6'b000010, 16'd0, 16'd0, 5'b00011, 1'b0);
    tick();
    chk_st("and.f1", 9'b000110000, 6'b000100, 16'd0, 16'd0, 5'd0, 1'b0);
    chk("and.f1.mdrread", {63'd0, MDRread}, 64'd1);
    tick();
    chk_st("and.f2", 9'b000000100, 6'b000001, 16'd0, 16'd0, 5'd0, 1'b0);
    tick();
    chk_st("and.t3", 9'b000001000, 6'd0, 16'd0, 16'h0008, 5'd0, 1'b0);
    tick();
    chk_st("and.t4", 9'b001000000, 6'd0, 16'd0, 16'h0080, 5'b00101, 1'b0);
    tick();
    chk_st("and.t5", 9'd0, 6'b000100, 16'h0010, 16'd0, 5'd0, 1'b1);
    tick();
    chk("and.r4", {32'd0, rf[4]}, 64'hA);
    chk("and.count", {48'd0, instr_count}, 64'd1);
    chk("and.next_f0", {63'd0, PCOut}, 64'd1);

    // MUL R0,R2,R5
    tick(); tick(); tick();
    chk("mul.t3.regOut", {48'd0, regOut}, 64'h0004);
    tick();
    chk_st("mul.t4", 9'b001000000, 6'd0, 16'd0, 16'h0020, 5'b01111, 1'b0);
    tick();
    chk_st("mul.t5", 9'b010000000, 6'b000100, 16'd0, 16'd0, 5'd0, 1'b0);
    tick();
    chk_st("mul.t6", 9'b100000000, 6'b001000, 16'd0, 16'd0, 5'd0, 1'b1);
    tick();
    chk("mul.hi", {32'd0, Hi}, 64'h1);
    chk("mul.lo", {32'd0, Lo}, 64'h2346_2345);
    chk("mul.count", {48'd0, instr_count}, 64'd2);

    // NOP with mem_ready low for three F1 cycles
    mem_ready = 1'b0;
    tick();
    chk("wait.f1.c1", {63'd0, MDRread}, 64'd1);
    tick(); tick(); tick();
    chk("wait.f1.c4", {63'd0, MDRread}, 64'd1);
    mem_ready = 1'b1;
    tick();
    chk("wait.f2.irin", {63'd0, IRIn}, 64'd1);
    tick();
    chk_st("nop.t3", 9'd0, 6'd0, 16'd0, 16'd0, 5'd0, 1'b1);
    tick();
    chk("nop.count", {48'd0, instr_count}, 64'd3);

    // Illegal opcode
    tick(); tick(); tick();
    chk_st("ill.t3", 9'd0, 6'd0, 16'd0, 16'd0, 5'd0, 1'b0);
    tick();
    chk("ill.fault", {63'd0, fault}, 64'd1);
    chk("ill.regIn", {48'd0, regIn}, 64'd0);
    pulse_start();
    chk("ill.sticky", {63'd0, fault}, 64'd1);
    chk("ill.no_fetch", {63'd0, PCOut}, 64'd0);
    clear = 1'b1;
    #1;
    chk("ill.clear.fault", {63'd0, fault}, 64'd0);
    chk("ill.clear.count", {48'd0, instr_count}, 64'd0);
    tick();
    clear = 1'b0;

    // HALT, then resume
    pulse_start();
    tick(); tick(); tick();
    chk_st("halt.t3", 9'd0, 6'd0, 16'd0, 16'd0, 5'd0, 1'b0);
    tick();
    chk("halt.halted", {63'd0, halted}, 64'd1);
    chk("halt.count", {48'd0, instr_count}, 64'd1);
    tick();
    chk("halt.hold", {63'd0, halted}, 64'd1);
    pulse_start();
    chk("halt.resume.halted", {63'd0, halted}, 64'd0);
    chk("halt.resume.f0", {63'd0, PCOut}, 64'd1);

    // ADD R6,R3,R7 with stop raised in T4
    tick(); tick(); tick(); tick();
    chk("stop.t4.zin", {63'd0, ZIn}, 64'd1);
    stop = 1'b1;
    tick();
    chk_st("stop.t5", 9'd0, 6'b000100, 16'h0040, 16'd0, 5'd0, 1'b1);
    tick();
    chk_st("stop.idle", 9'd0, 6'd0, 16'd0, 16'd0, 5'd0, 1'b0);
    chk("stop.count", {48'd0, instr_count}, 64'd2);
    chk("stop.r6", {32'd0, rf[6]}, 64'h19);
    stop = 1'b0;
    tick();
    chk("stop.stays_idle", {63'd0, PCOut}, 64'd0);

    // Memory timeout: 255 F1 cycles then FAULT
    mem_ready = 1'b0;
    pulse_start();
    tick();
    repeat (254) tick();
    chk("tmo.f1.c255.fault", {63'd0, fault}, 64'd0);
    chk("tmo.f1.c255.mdrread", {63'd0, MDRread}, 64'd1);
    tick();
    chk("tmo.fault", {63'd0, fault}, 64'd1);
    mem_ready = 1'b1;
    tick();
    chk("tmo.sticky", {63'd0, fault}, 64'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;

    // Clear asserted mid-T4
    pulse_start();
    tick(); tick(); tick(); tick();
    chk_st("clr.t4", 9'b001000000, 6'd0, 16'd0, 16'h0080, 5'b00011, 1'b0);
    #2;
    clear = 1'b1;
    #1;
    chk_st("clr.async", 9'd0, 6'd0, 16'd0, 16'd0, 5'd0, 1'b0);
    chk("clr.flags", {61'd0, MDRread, halted, fault}, 64'd0);
    chk("clr.count", {48'd0, instr_count}, 64'd0);
    tick();
    clear = 1'b0;
    tick();
    chk("clr.idle", {63'd0, PCOut}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
